// File: rtl/lifo_fifo_buffer.sv
// lifo_fifo_buffer: run-time LIFO/FIFO buffer on one array; define LIFO_FIFO_BUFFER_PEEK_EN to add peek_data.
module lifo_fifo_buffer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             mode_fifo,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
`ifdef LIFO_FIFO_BUFFER_PEEK_EN
  ,
  output logic [WIDTH-1:0] peek_data
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] hd, hd_inc, wr_idx, top_idx, rd_idx, wsel;
  logic [SW-1:0] sum;
  logic mode_q, m, do_pop, do_push;
  assign full        = count == DEPTH_C;
  assign empty       = count == '0;
  assign almost_full = count >= AF_C;
  always_comb begin
    m       = empty ? mode_fifo : mode_q;
    sum     = SW'(hd) + SW'(count);
    wr_idx  = (sum >= SW'(DEPTH)) ? AW'(sum - SW'(DEPTH)) : AW'(sum);
    top_idx = (wr_idx == '0) ? AW'(DEPTH - 1) : wr_idx - 1'b1;
    hd_inc  = (hd == AW'(DEPTH - 1)) ? '0 : hd + 1'b1;
    rd_idx  = m ? hd : top_idx;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    // a LIFO push+pop replaces the top; a FIFO one appends behind the tail
    wsel    = (do_pop && !m) ? top_idx : wr_idx;
  end
  always_ff @(posedge clk)
    if (do_push) mem[wsel] <= data_in;
  always_ff @(posedge clk) begin
    if (!rstN) begin
      count      <= '0;
      hd         <= '0;
      mode_q     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      mode_q     <= m;
      count      <= count + CW'(do_push) - CW'(do_pop);
      hd         <= (do_pop && m) ? hd_inc : hd;
      data_out   <= do_pop ? mem[rd_idx] : data_out;
      data_valid <= do_pop;
      overflow   <= push && !do_push;
      underflow  <= pop && !do_pop;
    end
  end
`ifdef LIFO_FIFO_BUFFER_PEEK_EN
  assign peek_data = empty ? '0 : mem[rd_idx];
`endif
endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// tb_lifo_fifo_buffer: scoreboard bench comparing the buffer against a queue-based reference.
module tb_lifo_fifo_buffer;
  localparam int W = 8, D = 16, AF = 14, CW = $clog2(D + 1);
  logic clk = 0, rstN = 0, mode_fifo = 0, push = 0, pop = 0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic data_valid, full, empty, almost_full, overflow, underflow;
  logic [CW-1:0] count;
`ifdef LIFO_FIFO_BUFFER_PEEK_EN
  logic [W-1:0] peek_data;
`endif
  lifo_fifo_buffer #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF)) dut (
    .clk(clk), .rstN(rstN), .mode_fifo(mode_fifo), .push(push), .pop(pop),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
`ifdef LIFO_FIFO_BUFFER_PEEK_EN
    , .peek_data(peek_data)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic dv, ovf, unf; logic [W-1:0] dout; int cnt;} st_t;
  st_t st_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mdl[$];
  logic mq = 1'b0;
  logic [W-1:0] mdout = '0;
  int checks = 0, failures = 0;
  st_t ms;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: a plain queue, pushed at the back, popped at the back (LIFO) or front (FIFO)
  task automatic op(input logic r, input logic p, input logic q, input logic [W-1:0] d, input logic md);
    st_t s;
    logic m;
    logic [W-1:0] v;
    @(negedge clk);
    rstN = r; push = p; pop = q; data_in = d; mode_fifo = md;
    s.dv = 0; s.ovf = 0; s.unf = 0;
    if (!r) begin
      mdl.delete(); mq = 0; mdout = '0;
    end else begin
      m = (mdl.size() == 0) ? md : mq;
      mq = m;
      if (q && mdl.size() > 0) begin
        v = m ? mdl.pop_front() : mdl.pop_back();
        mdout = v; s.dv = 1; exp_q.push_back(v);
        if (p) mdl.push_back(d);
      end else begin
        s.unf = q;
        if (p) begin
          if (mdl.size() < D) mdl.push_back(d);
          else s.ovf = 1;
        end
      end
    end
    s.dout = mdout; s.cnt = mdl.size();
    st_q.push_back(s);
  endtask
  task automatic pw(input logic [W-1:0] d, input logic md); op(1, 1, 0, d, md); endtask
  task automatic pp(input logic md); op(1, 0, 1, '0, md); endtask
  always @(posedge clk) begin
    #1;
    if (st_q.size() > 0) begin
      ms = st_q.pop_front();
      chk("count", 32'(count), 32'(ms.cnt));
      chk("empty", 32'(empty), 32'(ms.cnt == 0));
      chk("full", 32'(full), 32'(ms.cnt == D));
      chk("almost_full", 32'(almost_full), 32'(ms.cnt >= AF));
      chk("data_valid", 32'(data_valid), 32'(ms.dv));
      chk("overflow", 32'(overflow), 32'(ms.ovf));
      chk("underflow", 32'(underflow), 32'(ms.unf));
      chk("data_out_hold", 32'(data_out), 32'(ms.dout));
`ifdef LIFO_FIFO_BUFFER_PEEK_EN
      chk("peek", 32'(peek_data), (mdl.size() == 0) ? 32'd0 : 32'(mq ? mdl[0] : mdl[$]));
`endif
    end
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 32'(data_out), 32'hx);
      else chk("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end
  initial begin
    int bias;
    logic md;
    op(0, 0, 0, '0, 0);
    for (int i = 1; i <= 16; i++) pw(W'(i), 0);
    pw(8'hFF, 0);
    for (int i = 0; i < 17; i++) pp(0);
    for (int i = 0; i < 10; i++) pw(W'(8'hA0 + i), 1);
    for (int i = 0; i < 6; i++) pp(1);
    for (int i = 0; i < 12; i++) pw(W'(8'hB0 + i), 1);
    pw(8'hFF, 1);
    op(1, 1, 1, 8'h55, 1);
    for (int i = 0; i < 16; i++) pp(1);
    op(1, 1, 1, 8'h11, 0);
    pw(3, 0); pw(7, 0);
    op(1, 1, 1, 8'd9, 0);
    pp(0); pp(0);
    pw(8'h21, 0); pw(8'h22, 0);
    pp(1); pp(1);
    pw(8'h31, 1); pw(8'h32, 1); pp(1); pp(1);
    for (int i = 0; i < 5; i++) pw(W'(8'h40 + i), 0);
    op(0, 1, 0, 8'h99, 0);
    op(1, 0, 0, '0, 0);
    md = 0; bias = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) bias = $urandom_range(20, 80);
      if ($urandom_range(0, 19) == 0) md = ~md;
      op(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < bias), ($urandom_range(0, 99) >= bias - 10),
         W'($urandom), md);
    end
    op(1, 0, 0, '0, 0);
    op(1, 0, 0, '0, 0);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("status_drained", 32'(st_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
